// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - sensor bit map, fault state encoding and tank-level pattern check
package sensor_pkg;

  localparam int N_SENS = 7;
  localparam int IDX_H  = 0;
  localparam int IDX_M  = 1;
  localparam int IDX_L  = 2;
  localparam int IDX_US = 3;
  localparam int IDX_UA = 4;
  localparam int IDX_T  = 5;
  localparam int IDX_SD = 6;

  typedef enum logic [1:0] {OK, SUSPECT, FAULT, RECOVER} fault_state_e;

  // A tank fills from the bottom: a wet probe needs every probe below it wet too.
  function automatic logic level_valid(input logic h, input logic m, input logic l);
    return !(h && !m) && !(m && !l);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one-bit synchroniser plus hold-time debouncer with update strobe
module debounce_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic upd
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt    <= '0;
      dout   <= 1'b0;
      upd    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      upd    <= 1'b0;
      if (s == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        dout <= s;
        cnt  <= '0;
        upd  <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - sensor sync/debounce front end; SENSOR_LEVEL_CHECK_EN adds the level_fault FSM
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEB_CYCLES   = 50000,
  parameter int FAULT_CYCLES = 500000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_SENS-1:0] raw_in,
  output logic [N_SENS-1:0] sens_out,
  output logic              change_pulse,
  output logic              level_fault
);

  logic [N_SENS-1:0] upd;

  if (SYNC_STAGES < 2 || DEB_CYCLES < 1 || FAULT_CYCLES < 2) begin : g_bad_params
    $error("sensor_conditioner: parameter out of range");
  end

  for (genvar i = 0; i < N_SENS; i++) begin : g_deb
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clock  (clock),
      .reset_n(reset_n),
      .din    (raw_in[i]),
      .dout   (sens_out[i]),
      .upd    (upd[i])
    );
  end

  // Bits updating on the same edge collapse into one strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) change_pulse <= 1'b0;
    else          change_pulse <= |upd;
  end

`ifdef SENSOR_LEVEL_CHECK_EN
  localparam int FW = $clog2(FAULT_CYCLES) + 1;

  fault_state_e  state;
  logic [FW-1:0] fcnt;
  logic          lvl_ok;

  assign lvl_ok = level_valid(sens_out[IDX_H], sens_out[IDX_M], sens_out[IDX_L]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= OK;
      fcnt        <= '0;
      level_fault <= 1'b0;
    end else begin
      level_fault <= (state == FAULT) || (state == RECOVER);
      case (state)
        OK: begin
          if (!lvl_ok) begin
            state <= SUSPECT;
            fcnt  <= FW'(1);
          end
        end
        SUSPECT: begin
          if (lvl_ok)                               state <= OK;
          else if (fcnt == FW'(FAULT_CYCLES - 1))   state <= FAULT;
          else                                      fcnt  <= fcnt + FW'(1);
        end
        FAULT: begin
          if (lvl_ok) begin
            state <= RECOVER;
            fcnt  <= FW'(1);
          end
        end
        RECOVER: begin
          if (!lvl_ok)                              state <= FAULT;
          else if (fcnt == FW'(FAULT_CYCLES - 1))   state <= OK;
          else                                      fcnt  <= fcnt + FW'(1);
        end
        default: state <= OK;
      endcase
    end
  end
`else
  assign level_fault = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - directed and random checks of sensor_conditioner against a run-length model
module tb_sensor_conditioner;

  localparam int SS = 2;
  localparam int DC = 4;
  localparam int FC = 8;
`ifdef SENSOR_LEVEL_CHECK_EN
  localparam logic LF_ON = 1'b1;
`else
  localparam logic LF_ON = 1'b0;
`endif

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] raw_in  = 7'h00;
  logic [6:0] sens_out;
  logic       change_pulse;
  logic       level_fault;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  sensor_conditioner #(
    .SYNC_STAGES (SS),
    .DEB_CYCLES  (DC),
    .FAULT_CYCLES(FC)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .raw_in      (raw_in),
    .sens_out    (sens_out),
    .change_pulse(change_pulse),
    .level_fault (level_fault)
  );

  // Reference: raw delayed SS edges, a bit flips after DC consecutive differing samples,
  // fault sets after FC consecutive invalid patterns and clears after FC consecutive valid ones.
  logic [6:0] m_pipe [SS];
  logic [6:0] m_out;
  int         m_run [7];
  logic       m_chg, m_pulse, m_f, m_lf;
  int         m_inv, m_val;

  function automatic logic pat_valid(input logic [6:0] v);
    logic [2:0] hml;
    hml = {v[0], v[1], v[2]};
    return hml inside {3'b000, 3'b001, 3'b011, 3'b111};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_pipe[k] = '0;
    for (int i = 0; i < 7; i++) m_run[i] = 0;
    m_out = '0; m_chg = 0; m_pulse = 0; m_f = 0; m_lf = 0; m_inv = 0; m_val = 0;
  endtask

  task automatic model_edge(input logic [6:0] raw);
    logic [6:0] s, nout;
    s = m_pipe[SS-1];
    for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = raw;
    nout = m_out;
    for (int i = 0; i < 7; i++) begin
      if (s[i] != m_out[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          nout[i]  = s[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (LF_ON) begin
      m_lf = m_f;
      if (!m_f) begin
        if (!pat_valid(m_out)) begin
          m_inv++;
          if (m_inv == FC) begin m_f = 1; m_inv = 0; end
        end else m_inv = 0;
      end else begin
        if (pat_valid(m_out)) begin
          m_val++;
          if (m_val == FC) begin m_f = 0; m_val = 0; end
        end else m_val = 0;
      end
    end
    m_pulse = m_chg;
    m_chg   = (nout != m_out);
    m_out   = nout;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("sens_out", {25'd0, sens_out}, {25'd0, m_out});
    check("change_pulse", {31'd0, change_pulse}, {31'd0, m_pulse});
    check("level_fault", {31'd0, level_fault}, {31'd0, m_lf});
  endtask

  task automatic tick(input int n);
    logic [6:0] r;
    repeat (n) begin
      r = raw_in;
      @(posedge clock);
      if (!reset_n) model_reset();
      else          model_edge(r);
      #1;
      check_all();
    end
  endtask

  initial begin
    int rise, npulse;
    model_reset();

    // reset state
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // H rises: latency SS+DC, one strobe
    raw_in = 7'h01;
    rise = -1; npulse = 0;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (sens_out[0] && rise < 0) rise = c;
      if (change_pulse) npulse++;
    end
    check("t2_latency", rise, SS + DC);
    check("t2_pulses", npulse, 1);

    // 3-cycle glitch on Us is rejected
    raw_in = 7'h09;
    tick(3);
    raw_in = 7'h01;
    npulse = 0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (change_pulse) npulse++;
    end
    check("t3_out", {25'd0, sens_out}, 32'h01);
    check("t3_pulses", npulse, 0);

    // H,M,L together
    raw_in = 7'h00;
    tick(12);
    raw_in = 7'h07;
    npulse = 0;
    for (int c = 0; c < 14; c++) begin
      tick(1);
      if (change_pulse) npulse++;
    end
    check("t4_out", {25'd0, sens_out}, 32'h07);
    check("t4_pulses", npulse, 1);
    check("t4_fault", {31'd0, level_fault}, 32'd0);

    // async reset mid-activity
    raw_in = 7'h7F;
    tick(5);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("t1_out", {25'd0, sens_out}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    raw_in = 7'h00;
    tick(4);

    // fault set, hold across short valid window, clear
    raw_in = 7'h01;
    tick(25);
    check("t5_fault_set", {31'd0, level_fault}, {31'd0, LF_ON});
    raw_in = 7'h07;
    tick(5);
    raw_in = 7'h05;
    tick(12);
    check("t5_fault_hold", {31'd0, level_fault}, {31'd0, LF_ON});
    raw_in = 7'h07;
    tick(25);
    check("t5_fault_clr", {31'd0, level_fault}, 32'd0);

    // random holds, biased to exercise level patterns
    for (int seg = 0; seg < 60; seg++) begin
      raw_in = 7'($urandom);
      if ($urandom_range(0, 1) == 0) raw_in[2:0] = 3'b100;
      tick($urandom_range(1, 12));
    end
    raw_in = 7'h00;
    tick(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
